// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and step tables for lcd_frame_writer.
// Also holds the short timing constants selected by LCD_SIM_FAST_EN.
package lcd_pkg;

  typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_FRAME} state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_EHI, TX_ELO, TX_WAIT} tx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       rs;
    logic       nibble_only;
    logic       long_wait;
  } step_t;

  localparam logic [7:0] LCD_FUNCSET = 8'h28;
  localparam logic [7:0] LCD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_LINE2   = 8'hC0;

  localparam int unsigned FAST_E_PULSE_CYC      = 2;
  localparam int unsigned FAST_CMD_WAIT_CYC     = 4;
  localparam int unsigned FAST_CLEAR_WAIT_CYC   = 8;
  localparam int unsigned FAST_POWERUP_WAIT_CYC = 16;

  localparam logic [5:0] INIT_LAST  = 6'd7;
  localparam logic [5:0] FRAME_LAST = 6'd33;

  // Counters run from load value down to 0, so a wait of N cycles loads N-1; 0 behaves as 1.
  function automatic logic [19:0] wait_load(input int unsigned cyc);
    return (cyc == 0) ? '0 : 20'(cyc - 1);
  endfunction

  // Single-nibble init steps carry the nibble in the high half of data.
  function automatic step_t init_step(input logic [2:0] i);
    step_t s;
    s = '{data: 8'h30, rs: 1'b0, nibble_only: 1'b1, long_wait: 1'b1};
    case (i)
      3'd3:    s.data = 8'h20;
      3'd4:    s = '{data: LCD_FUNCSET, rs: 1'b0, nibble_only: 1'b0, long_wait: 1'b0};
      3'd5:    s = '{data: LCD_DISPON,  rs: 1'b0, nibble_only: 1'b0, long_wait: 1'b0};
      3'd6:    s = '{data: LCD_ENTRY,   rs: 1'b0, nibble_only: 1'b0, long_wait: 1'b0};
      3'd7:    s = '{data: LCD_CLEAR,   rs: 1'b0, nibble_only: 1'b0, long_wait: 1'b1};
      default: ;
    endcase
    return s;
  endfunction

  // Frame step j: 0 = line-1 address, 1..16 = chars 0..15, 17 = line-2 address, 18..33 = chars 16..31.
  function automatic step_t frame_step(input logic [5:0] j, input logic [255:0] text);
    step_t s;
    logic [4:0] k;
    k = (j < 6'd17) ? 5'(j - 6'd1) : 5'(j - 6'd2);
    s = '{data: text[{~k, 3'b000} +: 8], rs: 1'b1, nibble_only: 1'b0, long_wait: 1'b0};
    if (j == 6'd0)
      s = '{data: LCD_LINE1, rs: 1'b0, nibble_only: 1'b0, long_wait: 1'b0};
    else if (j == 6'd17)
      s = '{data: LCD_LINE2, rs: 1'b0, nibble_only: 1'b0, long_wait: 1'b0};
    return s;
  endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// LCD pin bundle (4-bit HD44780 write-only bus) driven by lcd_frame_writer.
interface lcd_frame_writer_if;
  logic       rslcd;
  logic       rwlcd;
  logic       elcd;
  logic [3:0] lcdd;

  modport master (output rslcd, rwlcd, elcd, lcdd);
  modport slave  (input  rslcd, rwlcd, elcd, lcdd);
endinterface

// File: rtl/lcd_nibble_tx.sv
// Nibble/byte transmitter: setup cycle, E high, E low per nibble, then post-byte wait.
// done is high during the final wait cycle so the next start chains with no gap.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned E_CYC   = 12,
  parameter int unsigned CMD_CYC = 2500,
  parameter int unsigned CLR_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         tx_byte,
  input  logic               rs,
  input  logic               nibble_only,
  input  logic               long_wait,
  output logic               done,
  lcd_frame_writer_if.master lcd
);

  localparam logic [19:0] E_LOAD   = wait_load(E_CYC);
  localparam logic [19:0] CMD_LOAD = wait_load(CMD_CYC);
  localparam logic [19:0] CLR_LOAD = wait_load(CLR_CYC);

  tx_state_t   state, state_n;
  logic [19:0] cnt, cnt_n;
  logic [3:0]  lo_nib, lo_nib_n, lcdd_n;
  logic        lo_pend, lo_pend_n, lw, lw_n, rs_n;

  assign done      = (state == TX_WAIT) && (cnt == '0);
  assign lcd.rwlcd = 1'b0;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lo_nib_n  = lo_nib;
    lo_pend_n = lo_pend;
    lw_n      = lw;
    rs_n      = lcd.rslcd;
    lcdd_n    = lcd.lcdd;
    case (state)
      TX_SETUP: begin
        state_n = TX_EHI;
        cnt_n   = E_LOAD;
      end
      TX_EHI: begin
        if (cnt == '0) begin
          state_n = TX_ELO;
          cnt_n   = E_LOAD;
        end else begin
          cnt_n = cnt - 20'd1;
        end
      end
      TX_ELO: begin
        if (cnt != '0) begin
          cnt_n = cnt - 20'd1;
        end else if (lo_pend) begin
          state_n   = TX_SETUP;
          lcdd_n    = lo_nib;
          lo_pend_n = 1'b0;
        end else begin
          state_n = TX_WAIT;
          cnt_n   = lw ? CLR_LOAD : CMD_LOAD;
        end
      end
      TX_WAIT: begin
        if (cnt != '0) cnt_n = cnt - 20'd1;
        else           state_n = TX_IDLE;
      end
      default: ;
    endcase
    if (start && (state == TX_IDLE || done)) begin
      state_n   = TX_SETUP;
      rs_n      = rs;
      lcdd_n    = tx_byte[7:4];
      lo_nib_n  = tx_byte[3:0];
      lo_pend_n = !nibble_only;
      lw_n      = long_wait;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      cnt       <= '0;
      lo_nib    <= '0;
      lo_pend   <= 1'b0;
      lw        <= 1'b0;
      lcd.elcd  <= 1'b0;
      lcd.rslcd <= 1'b0;
      lcd.lcdd  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lo_nib    <= lo_nib_n;
      lo_pend   <= lo_pend_n;
      lw        <= lw_n;
      lcd.elcd  <= (state_n == TX_EHI);
      lcd.rslcd <= rs_n;
      lcd.lcdd  <= lcdd_n;
    end
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// Drives a 16x2 HD44780 LCD in 4-bit mode: power-up wait, init, then full-frame rewrite per cls.
// Define LCD_SIM_FAST_EN to replace the timing parameters with short simulation values.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE_CYC      = 12,
  parameter int unsigned CMD_WAIT_CYC     = 2500,
  parameter int unsigned CLEAR_WAIT_CYC   = 100000,
  parameter int unsigned POWERUP_WAIT_CYC = 750000
) (
  input  logic               CCLK,
  input  logic               rst,
  input  logic               cls,
  input  logic [255:0]       strdata,
  lcd_frame_writer_if.master lcd,
  output logic               busy
);

`ifdef LCD_SIM_FAST_EN
  localparam int unsigned E_CYC   = FAST_E_PULSE_CYC;
  localparam int unsigned CMD_CYC = FAST_CMD_WAIT_CYC;
  localparam int unsigned CLR_CYC = FAST_CLEAR_WAIT_CYC;
  localparam int unsigned PWR_CYC = FAST_POWERUP_WAIT_CYC;
`else
  localparam int unsigned E_CYC   = E_PULSE_CYC;
  localparam int unsigned CMD_CYC = CMD_WAIT_CYC;
  localparam int unsigned CLR_CYC = CLEAR_WAIT_CYC;
  localparam int unsigned PWR_CYC = POWERUP_WAIT_CYC;
`endif

  localparam logic [19:0] PWR_LOAD = wait_load(PWR_CYC);

  state_t       state, state_n;
  logic [5:0]   idx, idx_n, nxt;
  logic [19:0]  pcnt;
  logic [255:0] shadow;
  logic         pending, kick, kick_n, frame_go;
  logic         start, done;
  step_t        step;

  assign busy = (state != ST_IDLE);
  assign nxt  = idx + 6'd1;

  // kick issues the first frame byte in the cycle after FRAME entry, so a frame can
  // follow INIT or another frame directly without ever passing through IDLE.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    kick_n   = 1'b0;
    start    = 1'b0;
    step     = '0;
    frame_go = 1'b0;
    case (state)
      ST_PWRUP: begin
        if (pcnt == '0) begin
          start   = 1'b1;
          step    = init_step(3'd0);
          state_n = ST_INIT;
          idx_n   = '0;
        end
      end
      ST_INIT, ST_FRAME: begin
        if (kick) begin
          start = 1'b1;
          step  = frame_step(6'd0, shadow);
        end else if (done) begin
          if (idx == ((state == ST_INIT) ? INIT_LAST : FRAME_LAST)) begin
            if (pending || cls) begin
              frame_go = 1'b1;
              state_n  = ST_FRAME;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = nxt;
            start = 1'b1;
            step  = (state == ST_INIT) ? init_step(nxt[2:0]) : frame_step(nxt, shadow);
          end
        end
      end
      ST_IDLE: begin
        if (pending || cls) begin
          frame_go = 1'b1;
          state_n  = ST_FRAME;
        end
      end
      default: state_n = ST_PWRUP;
    endcase
    if (frame_go) begin
      idx_n  = '0;
      kick_n = 1'b1;
    end
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      state   <= ST_PWRUP;
      idx     <= '0;
      pcnt    <= PWR_LOAD;
      pending <= 1'b0;
      kick    <= 1'b0;
      shadow  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      kick  <= kick_n;
      if (state == ST_PWRUP && pcnt != '0) pcnt <= pcnt - 20'd1;
      if (frame_go) begin
        pending <= 1'b0;
        shadow  <= strdata;
      end else if (cls) begin
        pending <= 1'b1;
      end
    end
  end

  lcd_nibble_tx #(
    .E_CYC   (E_CYC),
    .CMD_CYC (CMD_CYC),
    .CLR_CYC (CLR_CYC)
  ) u_tx (
    .clk         (CCLK),
    .rst         (rst),
    .start       (start),
    .tx_byte     (step.data),
    .rs          (step.rs),
    .nibble_only (step.nibble_only),
    .long_wait   (step.long_wait),
    .done        (done),
    .lcd         (lcd)
  );

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench for lcd_frame_writer: cycle-level expected pin queue built from the
// protocol rules, plus literal checks on init nibbles, frame bytes, reset and refresh handling.
module tb_lcd_frame_writer;

  localparam int unsigned E    = 2;
  localparam int unsigned CMDW = 4;
  localparam int unsigned CLRW = 8;
  localparam int unsigned PWRW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cls = 1'b0;
  logic [255:0] strdata = '0;
  logic         busy;

  lcd_frame_writer_if lcd_bus();

  lcd_frame_writer #(
    .E_PULSE_CYC      (E),
    .CMD_WAIT_CYC     (CMDW),
    .CLEAR_WAIT_CYC   (CLRW),
    .POWERUP_WAIT_CYC (PWRW)
  ) dut (
    .CCLK    (clk),
    .rst     (rst),
    .cls     (cls),
    .strdata (strdata),
    .lcd     (lcd_bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       e;
    logic       dchk;
    logic       rs;
    logic [3:0] d;
    logic       b;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [3:0] d;
  } nib_t;

  exp_t q[$];
  nib_t nlog[$];
  logic m_pend = 1'b0;

  // ---------------- reference model: expected pins per cycle ----------------
  function automatic void push(input logic e, input logic dchk, input logic rs,
                               input logic [3:0] d, input logic b);
    exp_t x;
    x.e = e; x.dchk = dchk; x.rs = rs; x.d = d; x.b = b;
    q.push_back(x);
  endfunction

  function automatic void push_wait(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
  endfunction

  function automatic void push_nib(input logic rs, input logic [3:0] d);
    push(1'b0, 1'b1, rs, d, 1'b1);
    for (int unsigned i = 0; i < E; i++) push(1'b1, 1'b1, rs, d, 1'b1);
    for (int unsigned i = 0; i < E; i++) push(1'b0, 1'b1, rs, d, 1'b1);
  endfunction

  function automatic void push_byte(input logic rs, input logic [7:0] b, input logic long_w);
    push_nib(rs, b[7:4]);
    push_nib(rs, b[3:0]);
    push_wait(long_w ? CLRW : CMDW);
  endfunction

  function automatic void model_reset();
    logic [3:0] n4;
    q.delete();
    m_pend = 1'b0;
    push_wait(PWRW - 1);
    for (int i = 0; i < 4; i++) begin
      n4 = (i == 3) ? 4'h2 : 4'h3;
      push_nib(1'b0, n4);
      push_wait(CLRW);
    end
    push_byte(1'b0, 8'h28, 1'b0);
    push_byte(1'b0, 8'h0C, 1'b0);
    push_byte(1'b0, 8'h06, 1'b0);
    push_byte(1'b0, 8'h01, 1'b1);
  endfunction

  function automatic void model_frame(input logic [255:0] txt);
    logic [7:0] ch;
    push(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    push_byte(1'b0, 8'h80, 1'b0);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) push_byte(1'b0, 8'hC0, 1'b0);
      ch = 8'(txt >> (8 * (31 - k)));
      push_byte(1'b1, ch, 1'b0);
    end
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    exp_t x;
    if (rst) begin
      model_reset();
    end else begin
      if (cls) m_pend = 1'b1;
      if (q.size() == 0) begin
        if (m_pend) begin
          m_pend = 1'b0;
          model_frame(strdata);
        end else begin
          push(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        end
      end
      x = q.pop_front();
      #2;
      n_chk++;
      if (lcd_bus.elcd !== x.e || busy !== x.b || lcd_bus.rwlcd !== 1'b0 ||
          (x.dchk && (lcd_bus.rslcd !== x.rs || lcd_bus.lcdd !== x.d))) begin
        n_fail++;
        $display("FAIL pins t=%0t: got e=%b rs=%b d=%h busy=%b rw=%b, expected e=%b rs=%b d=%h busy=%b (rs/d checked=%b)",
                 $time, lcd_bus.elcd, lcd_bus.rslcd, lcd_bus.lcdd, busy, lcd_bus.rwlcd,
                 x.e, x.rs, x.d, x.b, x.dchk);
      end
    end
  end

  // ---------------- nibble logger ----------------
  logic prev_e     = 1'b0;
  int   cyc        = 0;
  int   first_rise = -1;

  always @(posedge clk) begin
    nib_t n;
    #2;
    if (rst) cyc = 0;
    else     cyc++;
    if (lcd_bus.elcd === 1'b1 && prev_e === 1'b0) begin
      n.rs = lcd_bus.rslcd;
      n.d  = lcd_bus.lcdd;
      nlog.push_back(n);
      if (first_rise < 0) first_rise = cyc;
    end
    prev_e = lcd_bus.elcd;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_cls();
    @(negedge clk);
    cls = 1'b1;
    @(negedge clk);
    cls = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (busy !== 1'b0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check({name, " idle reached"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [8:0] byte_at(input int i);
    if (2 * i + 1 >= nlog.size()) return 9'h1FF;
    return {nlog[2*i].rs, nlog[2*i].d, nlog[2*i+1].d};
  endfunction

  logic [3:0] init_nibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] txt;
    logic         dropped;
    logic         found;
    int           c;

    rst = 1'b1;
    tick(3);
    check("reset busy",  {31'd0, busy},          32'd1);
    check("reset elcd",  {31'd0, lcd_bus.elcd},  32'd0);
    check("reset rslcd", {31'd0, lcd_bus.rslcd}, 32'd0);
    check("reset rwlcd", {31'd0, lcd_bus.rwlcd}, 32'd0);
    check("reset lcdd",  {28'd0, lcd_bus.lcdd},  32'd0);

    nlog.delete();
    first_rise = -1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle(400, "init");
    check("first elcd rise cycle", first_rise, 32'd17);
    check("init nibble count", nlog.size(), 32'd12);
    for (int i = 0; i < 12 && i < nlog.size(); i++)
      check($sformatf("init nibble %0d", i), {27'd0, nlog[i].rs, nlog[i].d}, {28'd0, init_nibs[i]});

    // Fixed text frame, strdata overwritten mid-frame without cls
    txt = "01234567 00 0123f01d01e01m01w01 ";
    strdata = txt;
    nlog.delete();
    pulse_cls();
    tick(40);
    strdata = {32{8'h41}};
    wait_idle(600, "frame1");
    check("frame1 nibble count", nlog.size(), 32'd68);
    check("frame1 byte0",  {23'd0, byte_at(0)},  32'h080);
    check("frame1 byte1",  {23'd0, byte_at(1)},  32'h130);
    check("frame1 byte8",  {23'd0, byte_at(8)},  32'h137);
    check("frame1 byte9",  {23'd0, byte_at(9)},  32'h120);
    check("frame1 byte17", {23'd0, byte_at(17)}, 32'h0C0);
    check("frame1 byte18", {23'd0, byte_at(18)}, 32'h166);
    check("frame1 byte20", {23'd0, byte_at(20)}, 32'h131);
    check("frame1 byte33", {23'd0, byte_at(33)}, 32'h120);

    // Two cls pulses during a frame collapse into one follow-on frame
    for (int w = 0; w < 8; w++) txt[w*32 +: 32] = $urandom;
    strdata = txt;
    nlog.delete();
    pulse_cls();
    tick(30);
    strdata = {32{8'h41}};
    pulse_cls();
    tick(50);
    pulse_cls();
    wait_idle(1200, "double cls");
    check("double cls nibble count", nlog.size(), 32'd136);
    check("frame A byte1 (orig text)", {23'd0, byte_at(1)}, {23'd0, 1'b1, txt[255:248]});
    check("frame B byte0",  {23'd0, byte_at(34)}, 32'h080);
    check("frame B byte1",  {23'd0, byte_at(35)}, 32'h141);
    check("frame B byte17", {23'd0, byte_at(51)}, 32'h0C0);
    check("frame B byte33", {23'd0, byte_at(67)}, 32'h141);

    // Random frames with random gaps and occasional extra cls while busy
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 8; w++) txt[w*32 +: 32] = $urandom;
      strdata = txt;
      tick($urandom_range(1, 20));
      pulse_cls();
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(5, 300));
        for (int w = 0; w < 8; w++) strdata[w*32 +: 32] = $urandom;
        pulse_cls();
      end
      wait_idle(1200, "random frame");
    end

    // cls during INIT: frame follows the clear wait with busy held
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    nlog.delete();
    strdata = txt;
    rst = 1'b0;
    tick(40);
    pulse_cls();
    dropped = 1'b0;
    c = 0;
    while (c < 1200 && !(nlog.size() >= 80 && busy === 1'b0)) begin
      @(negedge clk);
      if (busy === 1'b0 && nlog.size() < 80) dropped = 1'b1;
      c++;
    end
    check("init->frame busy held", {31'd0, dropped}, 32'd0);
    check("init+frame nibble count", nlog.size(), 32'd80);

    // Asynchronous reset mid-frame while elcd is high
    pulse_cls();
    tick(100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #3;
      found = lcd_bus.elcd;
    end
    check("elcd high found mid-frame", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check("async rst elcd", {31'd0, lcd_bus.elcd}, 32'd0);
    check("async rst busy", {31'd0, busy}, 32'd1);
    tick(2);
    nlog.delete();
    first_rise = -1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle(400, "re-init");
    check("re-init first rise", first_rise, 32'd17);
    check("re-init nibble count", nlog.size(), 32'd12);
    tick(60);
    check("no frame without cls", nlog.size(), 32'd12);
    check("idle after re-init", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Downstream consumer of the top-level debug-display string: it accepts the 32-character (256-bit) two-line frame that the pipeline top assembles and drives a 16x2 HD44780-class character LCD in 4-bit write-only mode. After reset it runs the panel power-up and initialisation sequence on its own. It then rewrites the full frame each time a refresh pulse arrives. It sits between the top-level string builder and the LCD pins.

## Interface
- E_PULSE_CYC, 12: cycles elcd is held high, and also the low gap after each nibble (≥240 ns at 50 MHz).
- CMD_WAIT_CYC, 2500: cycles waited after each ordinary byte (50 µs).
- CLEAR_WAIT_CYC, 100000: cycles waited after the clear command and after each init nibble (2 ms).
- POWERUP_WAIT_CYC, 750000: cycles waited after reset before the first nibble (15 ms).
- CCLK  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cls  in  1  refresh request; a one-cycle pulse is sufficient.
- strdata  in  256  frame text; [255:248] = line-1 column 0, [127:120] = line-2 column 0.
- rslcd  out  1  LCD RS (0 = command, 1 = data).
- rwlcd  out  1  LCD RW; constant 0.
- elcd  out  1  LCD enable strobe.
- lcdd  out  4  LCD DB7..DB4.
- busy  out  1  high while initialising or writing a frame.

## Operation
- States: PWRUP → INIT → IDLE → FRAME → IDLE.
- PWRUP: wait POWERUP_WAIT_CYC cycles.
- INIT:
  - Single nibbles 3, 3, 3, 2 are sent with rslcd=0, each followed by CLEAR_WAIT_CYC.
  - Then bytes 0x28, 0x0C, 0x06, 0x01 are sent with rslcd=0.
  - 0x01 is followed by CLEAR_WAIT_CYC; the other bytes by CMD_WAIT_CYC.
- IDLE: busy=0. A pending refresh starts FRAME.
- FRAME:
  - strdata is latched into a shadow register in the start cycle; later changes to strdata do not affect the frame.
  - Send sequence: 0x80 (rs=0), line-1 chars 0..15 (rs=1), 0xC0 (rs=0), line-2 chars 16..31 (rs=1).
  - That is 34 bytes = 68 E pulses.
- Byte send: high nibble first, then low nibble, then the post-byte wait.
- Refresh pending flag:
  - Set by cls in any state.
  - Cleared in the cycle FRAME starts.
  - cls arriving during INIT or FRAME is held. A new frame starts immediately after the current sequence ends, with busy staying high across the transition.
  - Multiple cls pulses while busy collapse into one frame.
- rst at any time aborts the current sequence, restarts at PWRUP and clears the pending flag.

## Timing
- Reset values: rslcd=0, rwlcd=0, elcd=0, lcdd=0, busy=1.
- Nibble:
  - 1 setup cycle with rslcd/lcdd valid and elcd=0.
  - Then E_PULSE_CYC cycles with elcd=1.
  - Then E_PULSE_CYC cycles with elcd=0.
  - rslcd/lcdd are stable through the whole nibble.
- Byte = 2 nibbles + post-wait.
- A cls seen in IDLE produces FRAME entry on the next cycle, with busy=1 in that cycle.
- busy falls in the cycle after the final wait of INIT or FRAME completes, and only if no refresh is pending.
- Wait counters are 20 bits wide and count down to 0; a parameter of 0 is treated as 1.

## Configuration
- LCD_SIM_FAST_EN defined: the parameters are overridden with E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8, POWERUP_WAIT_CYC=16. This gives nibble = 5 cycles and ordinary byte = 14 cycles, for short simulations.
- LCD_SIM_FAST_EN undefined: the parameter values apply unchanged; this is the synthesis build.

## Structure
- Package lcd_pkg holds:
  - the state encoding;
  - command constants LCD_FUNCSET=0x28, LCD_DISPON=0x0C, LCD_ENTRY=0x06, LCD_CLEAR=0x01, LCD_LINE1=0x80, LCD_LINE2=0xC0;
  - the fast-sim timing constants.
- Sub-module lcd_nibble_tx implements the nibble/byte transfer and post-wait:
  - inputs: start, byte, rs, nibble_only, long_wait;
  - output: done, a one-cycle pulse;
  - owns elcd, rslcd, lcdd and the wait counter.
- The top FSM sequences bytes and owns the shadow register, pending flag and busy.

## Test plan
All scenarios run with LCD_SIM_FAST_EN.
- Release rst → busy=1; first elcd rise at cycle 17 after release with lcdd=3, rslcd=0; 12 E pulses with nibbles 3,3,3,2,2,8,0,C,0,6,0,1; then busy=0.
- In IDLE, strdata="01234567 00 0123f01d01e01m01w01 " plus a cls pulse → 68 E pulses. Bytes decode as 0x80, 0x30..0x37, 0x20, 0x30, 0x30, 0x20, 0x30..0x33, 0xC0, 0x66, 0x30, 0x31, …, 0x20. rs=0 only for 0x80/0xC0. busy falls after the last byte.
- During a frame, change strdata to all 'A' without cls → the frame still matches the original text.
- During a frame, pulse cls twice with strdata all 'A' → the first frame finishes unchanged, exactly one second frame follows (32 × 0x41), and busy stays high between frames.
- cls pulse during INIT → the frame starts right after the 0x01 clear-wait, and busy never drops in between.
- Assert rst mid-frame with elcd=1 → elcd=0 and busy=1 immediately, with no clock edge required; after release the full INIT sequence repeats and no frame is sent without a new cls.
